// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin arbiter sharing one UART transmitter among N_REQ byte
//             sources. Optional tag byte per grant via `UART_ARB_TAG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int BUSY_WAIT = 4
`ifdef UART_ARB_TAG_EN
   ,parameter logic [3:0] TAG_BASE = 4'hA
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic [N_REQ-1:0]   i_req,
   input  logic [8*N_REQ-1:0] i_data,
   output logic [N_REQ-1:0]   o_ack,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_busy,
   output logic               o_timeout,
   output logic               o_transmit,
   output logic [7:0]         o_data_tx,
   input  logic               i_busy_tx
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(BUSY_WAIT + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3
`ifdef UART_ARB_TAG_EN
      ,TAG    = 3'd4
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic             transmit_q, transmit_d;
   logic             timeout_q, timeout_d;
   logic [7:0]       data_tx_q, data_tx_d;
   logic [PW-1:0]    widx_q, widx_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef UART_ARB_TAG_EN
   logic [7:0]       byte_q, byte_d;
   logic             tag_phase_q, tag_phase_d;
`endif

   logic             win_found;
   logic [PW-1:0]    win_idx;
   logic [PW-1:0]    cand;
   logic [7:0]       win_byte;
   logic [N_REQ-1:0] win_onehot;

   // Scan starts just after the last served source so every requester is reached.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = PW'((int'(ptr_q) + i) % N_REQ);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
      win_byte   = i_data[{win_idx, 3'b000} +: 8];
      win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ack_d      = '0;
      transmit_d = 1'b0;
      timeout_d  = 1'b0;
      data_tx_d  = data_tx_q;
      widx_d     = widx_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
`ifdef UART_ARB_TAG_EN
      byte_d      = byte_q;
      tag_phase_d = tag_phase_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_en && win_found && !i_busy_tx) begin
               widx_d     = win_idx;
               grant_d    = win_onehot;
               transmit_d = 1'b1;
`ifdef UART_ARB_TAG_EN
               byte_d      = win_byte;
               data_tx_d   = {TAG_BASE, 1'b0, 3'(win_idx)};
               tag_phase_d = 1'b1;
               state_d     = TAG;
`else
               data_tx_d  = win_byte;
               ack_d      = win_onehot;
               state_d    = SEND;
`endif
            end
         end
`ifdef UART_ARB_TAG_EN
         TAG: begin
            state_d = WAIT_HI;
            cnt_d   = '0;
         end
`endif
         SEND: begin
            state_d = WAIT_HI;
            cnt_d   = '0;
         end
         WAIT_HI: begin
            if (i_busy_tx) begin
               state_d = WAIT_LO;
            end else if (cnt_q == CW'(BUSY_WAIT - 2)) begin
               // UART never answered; give up on this transaction.
               timeout_d = 1'b1;
               state_d   = IDLE;
               grant_d   = '0;
`ifdef UART_ARB_TAG_EN
               if (!tag_phase_q) ptr_d = widx_q;
               tag_phase_d = 1'b0;
`else
               ptr_d     = widx_q;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_LO: begin
            if (!i_busy_tx) begin
`ifdef UART_ARB_TAG_EN
               if (tag_phase_q) begin
                  tag_phase_d = 1'b0;
                  transmit_d  = 1'b1;
                  ack_d       = grant_q;
                  data_tx_d   = byte_q;
                  state_d     = SEND;
               end else begin
                  state_d = IDLE;
                  ptr_d   = widx_q;
                  grant_d = '0;
               end
`else
               state_d = IDLE;
               ptr_d   = widx_q;
               grant_d = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ack_q      <= '0;
         transmit_q <= 1'b0;
         timeout_q  <= 1'b0;
         data_tx_q  <= '0;
         widx_q     <= '0;
         ptr_q      <= PW'(N_REQ - 1);
         cnt_q      <= '0;
`ifdef UART_ARB_TAG_EN
         byte_q      <= '0;
         tag_phase_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         transmit_q <= transmit_d;
         timeout_q  <= timeout_d;
         data_tx_q  <= data_tx_d;
         widx_q     <= widx_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
`ifdef UART_ARB_TAG_EN
         byte_q      <= byte_d;
         tag_phase_q <= tag_phase_d;
`endif
      end
   end

   assign o_ack      = ack_q;
   assign o_grant    = grant_q;
   assign o_busy     = (state_q != IDLE);
   assign o_timeout  = timeout_q;
   assign o_transmit = transmit_q;
   assign o_data_tx  = data_tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Directed self-checking bench for uart_tx_arbiter (N_REQ=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int N_REQ     = 4;
   localparam int BUSY_WAIT = 4;
   localparam int BUSY_LEN  = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic        busy;
   logic        timeout;
   logic        transmit;
   logic [7:0]  data_tx;
   logic        busy_tx;

   logic        bm_en    = 1'b0;
   logic        bm_start = 1'b0;
   logic        bm_busy  = 1'b0;
   int          bm_cnt   = 0;
   logic        busy_force = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   assign busy_tx = bm_busy | busy_force;

   uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_WAIT(BUSY_WAIT)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_req      (req),
      .i_data     (data),
      .o_ack      (ack),
      .o_grant    (grant),
      .o_busy     (busy),
      .o_timeout  (timeout),
      .o_transmit (transmit),
      .o_data_tx  (data_tx),
      .i_busy_tx  (busy_tx)
   );

   always #5 clk = ~clk;

   // UART stand-in: busy rises one cycle after a transmit pulse and lasts BUSY_LEN cycles.
   always @(negedge clk) begin
      if (bm_busy) begin
         bm_cnt = bm_cnt - 1;
         if (bm_cnt <= 0) bm_busy = 1'b0;
      end
      if (bm_start) begin
         bm_busy  = 1'b1;
         bm_cnt   = BUSY_LEN;
         bm_start = 1'b0;
      end
      if (transmit && bm_en) bm_start = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for a transmit pulse, checks the byte/grant/ack in that cycle,
   // then drops the request bits in clr.
   task automatic serve(input string tag, input logic [7:0] b, input logic [3:0] g,
                        input logic [3:0] a, input logic [3:0] clr);
      logic seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (transmit) seen = 1'b1;
      end
      check({tag, "_tx"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check({tag, "_data"}, {24'd0, data_tx}, {24'd0, b});
         check({tag, "_grant"}, {28'd0, grant}, {28'd0, g});
         check({tag, "_ack"}, {28'd0, ack}, {28'd0, a});
      end
      req = req & ~clr;
   endtask

   task automatic wait_idle(input string tag);
      logic done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic saw;
      rst  = 1'b1;
      en   = 1'b1;
      req  = 4'b0000;
      data = 32'h0;

      do_reset();
      check("rst_grant", {28'd0, grant}, 32'd0);
      check("rst_ack", {28'd0, ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_transmit", {31'd0, transmit}, 32'd0);
      check("rst_data_tx", {24'd0, data_tx}, 32'd0);

`ifdef UART_ARB_TAG_EN
      // Tag byte first without ack, then payload with ack.
      bm_en = 1'b1;
      data  = 32'h0041_0000;
      req   = 4'b0100;
      serve("t6_tag", 8'hA2, 4'b0100, 4'b0000, 4'b0000);
      serve("t6_pay", 8'h41, 4'b0100, 4'b0100, 4'b0100);
      wait_idle("t6");
`else
      // 1: single byte through the busy handshake.
      bm_en = 1'b1;
      data  = 32'h0000_005A;
      req   = 4'b0001;
      serve("t1", 8'h5A, 4'b0001, 4'b0001, 4'b0001);
      wait_idle("t1");
      check("t1_bus_low", {31'd0, busy_tx}, 32'd0);
      check("t1_grant_clr", {28'd0, grant}, 32'd0);
      check("t1_data_hold", {24'd0, data_tx}, 32'h5A);

      // 2: all four requesting, round-robin from source 0.
      do_reset();
      data = 32'h1312_1110;
      req  = 4'b1111;
      serve("t2_0", 8'h10, 4'b0001, 4'b0001, 4'b0000);
      serve("t2_1", 8'h11, 4'b0010, 4'b0010, 4'b0000);
      serve("t2_2", 8'h12, 4'b0100, 4'b0100, 4'b0000);
      serve("t2_3", 8'h13, 4'b1000, 4'b1000, 4'b0000);
      serve("t2_4", 8'h10, 4'b0001, 4'b0001, 4'b1111);
      wait_idle("t2");

      // 3: grant held back while the UART reports busy.
      busy_force = 1'b1;
      data = 32'h0022_0000;
      req  = 4'b0100;
      saw  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         saw = saw | transmit | (grant != 4'b0000);
      end
      check("t3_hold", {31'd0, saw}, 32'd0);
      busy_force = 1'b0;
      @(negedge clk);
      check("t3_tx", {31'd0, transmit}, 32'd1);
      check("t3_grant", {28'd0, grant}, 32'h4);
      check("t3_data", {24'd0, data_tx}, 32'h22);
      req = 4'b0000;
      wait_idle("t3");

      // 4: UART silent -> timeout four cycles after SEND.
      bm_en = 1'b0;
      data  = 32'h0000_6600;
      req   = 4'b0010;
      serve("t4", 8'h66, 4'b0010, 4'b0010, 4'b0010);
      saw = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         saw = saw | timeout;
      end
      check("t4_early_to", {31'd0, saw}, 32'd0);
      @(negedge clk);
      check("t4_timeout", {31'd0, timeout}, 32'd1);
      check("t4_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("t4_pulse", {31'd0, timeout}, 32'd0);

      // 5: reset while in WAIT_LO serving source 3.
      bm_en = 1'b1;
      data  = 32'h3300_0050;
      req   = 4'b1000;
      serve("t5_src3", 8'h33, 4'b1000, 4'b1000, 4'b0000);
      req = 4'b1001;
      @(negedge clk);
      @(negedge clk);
      check("t5_waitlo", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rst_grant", {28'd0, grant}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_data", {24'd0, data_tx}, 32'd0);
      check("t5_rst_ack", {28'd0, ack}, 32'd0);
      serve("t5_src0", 8'h50, 4'b0001, 4'b0001, 4'b1111);
      wait_idle("t5");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
